// File: rtl/food_spawner.sv
// Food slot manager: LFSR-driven placement of NUM_FOOD items, eat detection and respawn.
// Optional FOOD_SEED_PORT_EN adds a seed input that is loaded into the LFSR on reset.
module food_spawner #(
    parameter int          NUM_FOOD = 9,
    parameter int          CELL_PX  = 16,
    parameter int          COLS     = 40,
    parameter int          ROWS     = 30,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          headx,
    input  logic [8:0]          heady,
`ifdef FOOD_SEED_PORT_EN
    input  logic [15:0]         seed,
`endif
    output logic [9:0]          foodx [NUM_FOOD],
    output logic [8:0]          foody [NUM_FOOD],
    output logic [NUM_FOOD-1:0] food_valid,
    output logic                eat_pulse,
    output logic [3:0]          eat_slot,
    output logic                full
);

    // state   | meaning
    // S_IDLE  | every slot holds live food
    // S_GEN   | draw a candidate cell from the LFSR, retry if off-grid
    // S_CHECK | reject candidates on the head or on another live item
    // S_WRITE | commit the candidate into the target slot
    typedef enum logic [1:0] {S_IDLE, S_GEN, S_CHECK, S_WRITE} state_t;

    localparam logic [9:0]  SENT_X    = 10'h3FF;
    localparam logic [8:0]  SENT_Y    = 9'h1FF;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] ALT_SEED  = 16'hACE1;
    localparam logic [9:0]  CELL_X    = 10'(CELL_PX);
    localparam logic [8:0]  CELL_Y    = 9'(CELL_PX);
    localparam logic [6:0]  COLS_L    = 7'(COLS);
    localparam logic [5:0]  ROWS_L    = 6'(ROWS);

    if (NUM_FOOD < 1 || NUM_FOOD > 16 || COLS < 1 || COLS > 64 || ROWS < 1 || ROWS > 32 ||
        (COLS - 1) * CELL_PX > 1023 || (ROWS - 1) * CELL_PX > 511) begin : g_bad_params
        $error("food_spawner: parameter combination does not fit the coordinate widths");
    end

    logic [15:0] seed_init;
`ifdef FOOD_SEED_PORT_EN
    assign seed_init = (seed == 16'h0) ? ALT_SEED : seed;
`else
    assign seed_init = (SEED == 16'h0) ? ALT_SEED : SEED;
`endif

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [5:0]          cx_q, cx_d;
    logic [4:0]          cy_q, cy_d;
    logic [3:0]          tgt_q, tgt_d;
    logic [NUM_FOOD-1:0] food_valid_q, food_valid_d;
    logic [9:0]          foodx_q [NUM_FOOD];
    logic [9:0]          foodx_d [NUM_FOOD];
    logic [8:0]          foody_q [NUM_FOOD];
    logic [8:0]          foody_d [NUM_FOOD];
    logic                eat_pulse_q, eat_pulse_d;
    logic [3:0]          eat_slot_q, eat_slot_d;
    logic                full_q, full_d;

    logic [9:0]          cand_x;
    logic [8:0]          cand_y;
    logic                hit;
    logic                eaten;
    logic [NUM_FOOD-1:0] remain;

    function automatic logic [3:0] lowest_zero(input logic [NUM_FOOD-1:0] m);
        lowest_zero = '0;
        for (int i = NUM_FOOD - 1; i >= 0; i--) begin
            if (!m[i]) lowest_zero = 4'(i);
        end
    endfunction

    assign cand_x = {4'b0, cx_q} * CELL_X;
    assign cand_y = {4'b0, cy_q} * CELL_Y;
    assign remain = food_valid_q | (NUM_FOOD'(1) << tgt_q);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
        cx_d         = cx_q;
        cy_d         = cy_q;
        tgt_d        = tgt_q;
        food_valid_d = food_valid_q;
        foodx_d      = foodx_q;
        foody_d      = foody_q;
        eat_pulse_d  = 1'b0;
        eat_slot_d   = eat_slot_q;
        eaten        = 1'b0;
        hit          = (cand_x == headx) && (cand_y == heady);

        for (int i = 0; i < NUM_FOOD; i++) begin
            if (food_valid_q[i] && foodx_q[i] == cand_x && foody_q[i] == cand_y) hit = 1'b1;
            if (!eaten && food_valid_q[i] && foodx_q[i] == headx && foody_q[i] == heady) begin
                eaten           = 1'b1;
                food_valid_d[i] = 1'b0;
                foodx_d[i]      = SENT_X;
                foody_d[i]      = SENT_Y;
                eat_pulse_d     = 1'b1;
                eat_slot_d      = 4'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!(&food_valid_q)) begin
                    tgt_d   = lowest_zero(food_valid_q);
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                cx_d = lfsr_q[5:0];
                cy_d = lfsr_q[12:8];
                if ({1'b0, lfsr_q[5:0]} < COLS_L && {1'b0, lfsr_q[12:8]} < ROWS_L) state_d = S_CHECK;
            end
            S_CHECK: state_d = hit ? S_GEN : S_WRITE;
            S_WRITE: begin
                // The target slot is never live, so an eat this cycle cannot collide with it.
                foodx_d[tgt_q]      = cand_x;
                foody_d[tgt_q]      = cand_y;
                food_valid_d[tgt_q] = 1'b1;
                if (!(&remain)) begin
                    tgt_d   = lowest_zero(remain);
                    state_d = S_GEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        full_d = &food_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= seed_init;
            cx_q         <= '0;
            cy_q         <= '0;
            tgt_q        <= '0;
            food_valid_q <= '0;
            foodx_q      <= '{default: SENT_X};
            foody_q      <= '{default: SENT_Y};
            eat_pulse_q  <= 1'b0;
            eat_slot_q   <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            tgt_q        <= tgt_d;
            food_valid_q <= food_valid_d;
            foodx_q      <= foodx_d;
            foody_q      <= foody_d;
            eat_pulse_q  <= eat_pulse_d;
            eat_slot_q   <= eat_slot_d;
            full_q       <= full_d;
        end
    end

    assign foodx      = foodx_q;
    assign foody      = foody_q;
    assign food_valid = food_valid_q;
    assign eat_pulse  = eat_pulse_q;
    assign eat_slot   = eat_slot_q;
    assign full       = full_q;

endmodule

// File: tb/tb_food_spawner.sv
// Randomized bench for food_spawner against a cycle-stepped behavioural model of the
// food slots, plus directed fill / eat / reset-abort / sentinel scenarios.
module tb_food_spawner;
    localparam int NF   = 9;
    localparam int CELL = 16;
    localparam int NCOL = 40;
    localparam int NROW = 30;
    localparam int PH_NONE = 0, PH_DRAW = 1, PH_VET = 2, PH_PLACE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    headx = '0;
    logic [8:0]    heady = '0;
`ifdef FOOD_SEED_PORT_EN
    logic [15:0]   seed = 16'h0;
`endif
    logic [9:0]    foodx [NF];
    logic [8:0]    foody [NF];
    logic [NF-1:0] food_valid;
    logic          eat_pulse;
    logic [3:0]    eat_slot;
    logic          full;

    always #5 clk = ~clk;

    food_spawner dut (
        .clk        (clk),
        .reset      (reset),
        .headx      (headx),
        .heady      (heady),
`ifdef FOOD_SEED_PORT_EN
        .seed       (seed),
`endif
        .foodx      (foodx),
        .foody      (foody),
        .food_valid (food_valid),
        .eat_pulse  (eat_pulse),
        .eat_slot   (eat_slot),
        .full       (full)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: slot table plus one pending placement job.
    int m_lfsr;
    int m_x [NF];
    int m_y [NF];
    bit m_v [NF];
    bit m_pulse;
    int m_slot;
    bit m_full;
    int ph;
    int job;
    int cand_x, cand_y;

    function automatic int model_seed();
`ifdef FOOD_SEED_PORT_EN
        return (seed == 16'h0) ? 'hACE1 : int'(seed);
`else
        return 'hACE1;
`endif
    endfunction

    function automatic int first_free(input bit v [NF]);
        for (int i = 0; i < NF; i++) if (!v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        int ox [NF];
        int oy [NF];
        bit ov [NF];
        bit clash;
        int ff;
        if (reset) begin
            m_lfsr  = model_seed();
            for (int i = 0; i < NF; i++) begin
                m_x[i] = 1023; m_y[i] = 511; m_v[i] = 0;
            end
            m_pulse = 0; m_slot = 0; m_full = 0; ph = PH_NONE; job = 0;
        end else begin
            ox = m_x; oy = m_y; ov = m_v;
            m_pulse = 0;
            for (int i = 0; i < NF; i++) begin
                if (ov[i] && ox[i] == int'(headx) && oy[i] == int'(heady)) begin
                    m_pulse = 1; m_slot = i; m_v[i] = 0; m_x[i] = 1023; m_y[i] = 511;
                    break;
                end
            end
            case (ph)
                PH_NONE: begin
                    ff = first_free(ov);
                    if (ff >= 0) begin job = ff; ph = PH_DRAW; end
                end
                PH_DRAW: begin
                    cand_x = (m_lfsr % 64) * CELL;
                    cand_y = ((m_lfsr / 256) % 32) * CELL;
                    if (m_lfsr % 64 < NCOL && (m_lfsr / 256) % 32 < NROW) ph = PH_VET;
                end
                PH_VET: begin
                    clash = (cand_x == int'(headx) && cand_y == int'(heady));
                    for (int i = 0; i < NF; i++)
                        if (ov[i] && ox[i] == cand_x && oy[i] == cand_y) clash = 1;
                    ph = clash ? PH_DRAW : PH_PLACE;
                end
                default: begin
                    m_x[job] = cand_x; m_y[job] = cand_y; m_v[job] = 1;
                    ov[job] = 1;
                    ff = first_free(ov);
                    if (ff >= 0) begin job = ff; ph = PH_DRAW; end
                    else ph = PH_NONE;
                end
            endcase
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
            m_full = 1;
            for (int i = 0; i < NF; i++) if (!m_v[i]) m_full = 0;
        end
    end

    bit chk_en = 0;
    int pulse_cnt = 0;

    always @(negedge clk) begin
        logic [NF-1:0] mv;
        if (eat_pulse === 1'b1) pulse_cnt++;
        if (chk_en) begin
            for (int i = 0; i < NF; i++) begin
                mv[i] = m_v[i];
                check("slot_pos", 32'({foodx[i], foody[i]}), 32'({10'(m_x[i]), 9'(m_y[i])}));
            end
            check("valid", 32'(food_valid), 32'(mv));
            check("full", 32'(full), 32'(m_full));
            check("eat_pulse", 32'(eat_pulse), 32'(m_pulse));
            if (m_pulse) check("eat_slot", 32'(eat_slot), 32'(m_slot));
        end
    end

    task automatic wait_full(input int budget, input string tag);
        int k = 0;
        while (full !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(full), 32'd1);
    endtask

    function automatic int popcount(input logic [NF-1:0] v);
        int n = 0;
        for (int i = 0; i < NF; i++) if (v[i]) n++;
        return n;
    endfunction

    initial begin
        bit ok;
        int p0;
        int k;
        int r;
        int j;

        // reset state
        @(posedge clk);
        #1 chk_en = 1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(food_valid), 32'd0);
        check("rst_pulse", 32'(eat_pulse), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        ok = 1;
        for (int i = 0; i < NF; i++) if (foodx[i] !== 10'h3FF || foody[i] !== 9'h1FF) ok = 0;
        check("rst_sentinel", 32'(ok), 32'd1);

        // fill with head parked at (320,240)
        headx = 10'd320; heady = 9'd240; reset = 0;
        wait_full(200, "fill_full");
        ok = 1;
        for (int i = 0; i < NF; i++) begin
            if (foodx[i] % 16 != 0 || foody[i] % 16 != 0 || foodx[i] >= 640 || foody[i] >= 480) ok = 0;
            if (foodx[i] == 10'd320 && foody[i] == 9'd240) ok = 0;
            for (int q = i + 1; q < NF; q++)
                if (foodx[i] == foodx[q] && foody[i] == foody[q]) ok = 0;
        end
        check("fill_layout", 32'(ok), 32'd1);

        // park the head on slot 3 for 10 cycles
        headx = 10'(m_x[3]); heady = 9'(m_y[3]);
        p0 = pulse_cnt;
        @(negedge clk);
        check("eat3_pulse", 32'(eat_pulse), 32'd1);
        check("eat3_slot", 32'(eat_slot), 32'd3);
        check("eat3_valid", 32'(food_valid[3]), 32'd0);
        repeat (9) @(negedge clk);
        check("park_one_pulse", 32'(pulse_cnt - p0), 32'd1);
        wait_full(100, "refill_full");
        check("respawn_off_head", 32'(foodx[3] == headx && foody[3] == heady), 32'd0);

        // sentinel head, then reset while a candidate is being vetted
        headx = 10'h3FF; heady = 9'h1FF; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        p0 = pulse_cnt;
        k = 0;
        while (!(popcount(food_valid) >= 3 && ph == PH_VET) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reached_check", 32'(k < 300), 32'd1);
        reset = 1;
        @(negedge clk);
        check("abort_valid", 32'(food_valid), 32'd0);
        ok = 1;
        for (int i = 0; i < NF; i++) if (foodx[i] !== 10'h3FF || foody[i] !== 9'h1FF) ok = 0;
        check("abort_sentinel", 32'(ok), 32'd1);
        reset = 0;
        wait_full(200, "sentinel_fill");
        repeat (5) @(negedge clk);
        check("sentinel_no_eat", 32'(pulse_cnt - p0), 32'd0);

        // randomized head movement with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (reset) begin
                reset = 0;
            end else if (r < 1) begin
                reset = 1;
`ifdef FOOD_SEED_PORT_EN
                case ($urandom_range(0, 2))
                    0: seed = 16'h0;
                    1: seed = 16'hACE1;
                    default: seed = 16'($urandom_range(1, 65535));
                endcase
`endif
            end else if (r < 30) begin
                j = $urandom_range(0, NF - 1);
                if (m_v[j]) begin headx = 10'(m_x[j]); heady = 9'(m_y[j]); end
            end else if (r < 45) begin
                headx = 10'($urandom_range(0, NCOL - 1) * CELL);
                heady = 9'($urandom_range(0, NROW - 1) * CELL);
            end else if (r < 50) begin
                headx = 10'($urandom_range(0, 1023));
                heady = 9'($urandom_range(0, 511));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
